// File: rtl/clk_phase_gen_pkg.sv
// Shared types and elaboration helpers for the machine-cycle phase generator.
package clk_phase_gen_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STABILISE,
    ST_RST_HOLD,
    ST_RUN,
    ST_STOPPED
  } state_t;

  function automatic int unsigned idx_width(input int unsigned phases);
    return (phases <= 2) ? 1 : $clog2(phases);
  endfunction

  function automatic bit params_legal(input int unsigned phases,
                                      input int unsigned div,
                                      input int unsigned stable_cycles,
                                      input int unsigned sync_rst_cycles);
    return (phases >= 2) && (phases % 2 == 0) && (div >= 1) &&
           (stable_cycles >= 1) && (sync_rst_cycles >= 1);
  endfunction

endpackage

// File: rtl/clk_phase_gen_phase_seq.sv
// Tick/phase counter pair: DIV ticks per phase, PHASES phases per machine cycle.
module phase_seq
  import clk_phase_gen_pkg::*;
#(
  parameter int unsigned PHASES = 4,
  parameter int unsigned DIV    = 1
) (
  input  logic                         CLK,
  input  logic                         en,
  input  logic                         clr,
  output logic [idx_width(PHASES)-1:0] phase_idx,
  output logic                         first_tick,
  output logic                         last_tick,
  output logic                         wrap
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = idx_width(PHASES);
  localparam logic [TW-1:0] TICK_MAX  = TW'(DIV - 1);
  localparam logic [IW-1:0] PHASE_MAX = IW'(PHASES - 1);

  logic [TW-1:0] tick_q;

  always_ff @(posedge CLK) begin
    if (clr) begin
      tick_q    <= '0;
      phase_idx <= '0;
    end else if (en) begin
      if (last_tick) begin
        tick_q    <= '0;
        phase_idx <= wrap ? '0 : phase_idx + IW'(1);
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  assign first_tick = (tick_q == '0);
  assign last_tick  = (tick_q == TICK_MAX);
  assign wrap       = last_tick && (phase_idx == PHASE_MAX);

endmodule

// File: rtl/clk_phase_gen.sv
// Machine-cycle phase / strobe generator with oscillator stabilisation,
// CPU reset hold and boundary-aligned stop/resume.
module clk_phase_gen
  import clk_phase_gen_pkg::*;
#(
  parameter int unsigned PHASES          = 4,
  parameter int unsigned DIV             = 1,
  parameter int unsigned STABLE_CYCLES   = 16,
  parameter int unsigned SYNC_RST_CYCLES = 2
) (
  input  logic                         CLK,
  input  logic                         nRESET,
  input  logic                         OSC_ENA,
  input  logic                         CLK_ENA,
  output logic [PHASES-1:0]            PHASE,
  output logic [idx_width(PHASES)-1:0] PHASE_IDX,
  output logic                         MAIN_CLK_P,
  output logic                         DATA_CLK_P,
  output logic                         ADR_CLK_P,
  output logic                         INC_CLK_P,
  output logic                         LATCH_CLK,
  output logic                         OSC_STABLE,
  output logic                         SYNC_RESET,
  output logic                         STOP_ACK
);

  localparam int unsigned IW = idx_width(PHASES);
  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HW = $clog2(SYNC_RST_CYCLES + 1);

  if (!params_legal(PHASES, DIV, STABLE_CYCLES, SYNC_RST_CYCLES)) begin : g_bad_params
    $error("clk_phase_gen: PHASES must be even >=2, DIV/STABLE_CYCLES/SYNC_RST_CYCLES >=1");
  end

  state_t        state_q;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic          osc_stable_q;
  logic          sync_reset_q;
  logic          stop_ack_q;

  logic          seq_en;
  logic          seq_clr;
  logic [IW-1:0] seq_idx;
  logic          seq_first;
  logic          seq_last;
  logic          seq_wrap;

  phase_seq #(
    .PHASES (PHASES),
    .DIV    (DIV)
  ) u_seq (
    .CLK        (CLK),
    .en         (seq_en),
    .clr        (seq_clr),
    .phase_idx  (seq_idx),
    .first_tick (seq_first),
    .last_tick  (seq_last),
    .wrap       (seq_wrap)
  );

  // Counters are held at phase 0 / tick 0 outside sequencing, so entering
  // RST_HOLD or resuming RUN lands on the first tick of phase 0.
  always_comb begin
    seq_clr = 1'b1;
    seq_en  = 1'b0;
    if (nRESET && OSC_ENA) begin
      case (state_q)
        ST_RST_HOLD: begin
          seq_clr = 1'b0;
          seq_en  = 1'b1;
        end
        ST_RUN: begin
          if (!(seq_wrap && !CLK_ENA)) begin
            seq_clr = 1'b0;
            seq_en  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET || !OSC_ENA) begin
      state_q      <= ST_OFF;
      stab_cnt     <= '0;
      hold_cnt     <= '0;
      osc_stable_q <= 1'b0;
      sync_reset_q <= 1'b1;
      stop_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (STABLE_CYCLES == 1) begin
            state_q      <= ST_RST_HOLD;
            osc_stable_q <= 1'b1;
          end else begin
            state_q  <= ST_STABILISE;
            stab_cnt <= SW'(1);
          end
        end
        ST_STABILISE: begin
          if (stab_cnt == SW'(STABLE_CYCLES - 1)) begin
            state_q      <= ST_RST_HOLD;
            stab_cnt     <= '0;
            osc_stable_q <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
        ST_RST_HOLD: begin
          if (seq_wrap) begin
            if (hold_cnt == HW'(SYNC_RST_CYCLES - 1)) begin
              state_q      <= ST_RUN;
              hold_cnt     <= '0;
              sync_reset_q <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        ST_RUN: begin
          if (seq_wrap && !CLK_ENA) begin
            state_q    <= ST_STOPPED;
            stop_ack_q <= 1'b1;
          end
        end
        ST_STOPPED: begin
          if (CLK_ENA) begin
            state_q    <= ST_RUN;
            stop_ack_q <= 1'b0;
          end
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  logic active;
  logic main_half;

  always_comb begin
    active     = (state_q == ST_RST_HOLD) || (state_q == ST_RUN);
    main_half  = (seq_idx < IW'(PHASES / 2));
    PHASE      = active ? (PHASES'(1) << seq_idx) : '0;
    PHASE_IDX  = active ? seq_idx : '0;
    MAIN_CLK_P = active && main_half;
    DATA_CLK_P = active && !main_half;
    ADR_CLK_P  = active && (seq_idx != '0);
    INC_CLK_P  = active && seq_wrap;
    LATCH_CLK  = active && seq_first && (seq_idx == '0);
  end

  assign OSC_STABLE = osc_stable_q;
  assign SYNC_RESET = sync_reset_q;
  assign STOP_ACK   = stop_ack_q;

endmodule

// File: tb/tb_clk_phase_gen.sv
// Self-checking bench: directed table, corner sequences and random stimulus
// against an arithmetic model, on a default instance and an 8-phase/DIV=3 one.
module tb_clk_phase_gen;

  logic CLK = 1'b0;
  logic nRESET = 1'b0, OSC_ENA = 1'b0, CLK_ENA = 1'b0;

  logic [3:0] phase4; logic [1:0] idx4;
  logic main4, data4, adr4, inc4, latch4, stab4, sync4, ack4;
  logic [7:0] phase8; logic [2:0] idx8;
  logic main8, data8, adr8, inc8, latch8, stab8, sync8, ack8;

  always #5 CLK = ~CLK;

  clk_phase_gen dut4 (
    .CLK(CLK), .nRESET(nRESET), .OSC_ENA(OSC_ENA), .CLK_ENA(CLK_ENA),
    .PHASE(phase4), .PHASE_IDX(idx4), .MAIN_CLK_P(main4), .DATA_CLK_P(data4),
    .ADR_CLK_P(adr4), .INC_CLK_P(inc4), .LATCH_CLK(latch4), .OSC_STABLE(stab4),
    .SYNC_RESET(sync4), .STOP_ACK(ack4)
  );

  clk_phase_gen #(.PHASES(8), .DIV(3), .STABLE_CYCLES(4), .SYNC_RST_CYCLES(1)) dut8 (
    .CLK(CLK), .nRESET(nRESET), .OSC_ENA(OSC_ENA), .CLK_ENA(CLK_ENA),
    .PHASE(phase8), .PHASE_IDX(idx8), .MAIN_CLK_P(main8), .DATA_CLK_P(data8),
    .ADR_CLK_P(adr8), .INC_CLK_P(inc8), .LATCH_CLK(latch8), .OSC_STABLE(stab8),
    .SYNC_RESET(sync8), .STOP_ACK(ack8)
  );

  logic [23:0] v4, v8;
  assign v4 = {4'b0, phase4, 1'b0, idx4, 5'b0,
               main4, data4, adr4, inc4, latch4, stab4, sync4, ack4};
  assign v8 = {phase8, idx8, 5'b0,
               main8, data8, adr8, inc8, latch8, stab8, sync8, ack8};

  localparam int M_OFF = 0, M_STAB = 1, M_HOLD = 2, M_RUN = 3, M_STOP = 4;

  typedef struct packed {
    int mode;
    int stab;
    int n;     // CLK cycles into the current machine cycle
    int cyc;   // completed machine cycles in reset hold
  } mdl_t;

  mdl_t m4, m8;
  int   errors = 0;
  int   checks = 0;

  function automatic mdl_t mstep(mdl_t s, bit r, bit o, bit e,
                                 int P, int D, int S, int H);
    mdl_t t = s;
    if (!r || !o) begin
      t.mode = M_OFF; t.stab = 0; t.n = 0; t.cyc = 0;
      return t;
    end
    case (s.mode)
      M_OFF, M_STAB: begin
        t.stab = s.stab + 1;
        if (t.stab >= S) begin
          t.mode = M_HOLD; t.n = 0; t.cyc = 0;
        end else t.mode = M_STAB;
      end
      M_HOLD: begin
        t.n = s.n + 1;
        if (t.n == P * D) begin
          t.n = 0; t.cyc = s.cyc + 1;
          if (t.cyc == H) t.mode = M_RUN;
        end
      end
      M_RUN: begin
        if (s.n == P * D - 1 && !e) t.mode = M_STOP;
        else t.n = (s.n + 1) % (P * D);
      end
      M_STOP: if (e) begin t.mode = M_RUN; t.n = 0; end
      default: ;
    endcase
    return t;
  endfunction

  function automatic logic [23:0] mexp(mdl_t s, int P, int D);
    int ph, tk;
    bit act;
    logic [7:0] oh;
    act = (s.mode == M_HOLD) || (s.mode == M_RUN);
    ph  = act ? s.n / D : 0;
    tk  = s.n % D;
    oh  = act ? 8'(1 << ph) : 8'h00;
    return {oh, 3'(ph), 5'b0,
            act && (ph < P / 2), act && (ph >= P / 2), act && (ph != 0),
            act && (ph == P - 1) && (tk == D - 1), act && (s.n == 0),
            s.mode >= M_HOLD, s.mode < M_RUN, s.mode == M_STOP};
  endfunction

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic step(input bit r, input bit o, input bit e);
    nRESET = r; OSC_ENA = o; CLK_ENA = e;
    @(posedge CLK);
    m4 = mstep(m4, r, o, e, 4, 1, 16, 2);
    m8 = mstep(m8, r, o, e, 8, 3, 4, 1);
    #1;
    chk("model_p4", v4, mexp(m4, 4, 1));
    chk("model_p8", v8, mexp(m8, 8, 3));
  endtask

  // {PHASE, LATCH, INC, OSC_STABLE, SYNC_RESET, STOP_ACK} after the last edge of a row
  typedef struct packed {
    bit         r;
    bit         o;
    bit         e;
    int         reps;
    logic [8:0] want;
  } row_t;

  row_t tbl [13];
  int   main_cnt, adr_low_cnt, inc_cnt;

  initial begin
    m4 = '0;
    m8 = '0;
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 2,  {4'b0000, 5'b00010}};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 15, {4'b0000, 5'b00010}};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1,  {4'b0001, 5'b10110}};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 3,  {4'b1000, 5'b01110}};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1,  {4'b0001, 5'b10110}};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 3,  {4'b1000, 5'b01110}};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1,  {4'b0001, 5'b10100}};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1,  {4'b0010, 5'b00100}};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 2,  {4'b1000, 5'b01100}};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1,  {4'b0000, 5'b00101}};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 3,  {4'b0000, 5'b00101}};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1,  {4'b0001, 5'b10100}};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1,  {4'b0000, 5'b00010}};

    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < tbl[i].reps; k++) step(tbl[i].r, tbl[i].o, tbl[i].e);
      chk($sformatf("table_row%0d", i),
          24'({phase4, latch4, inc4, stab4, sync4, ack4}), 24'(tbl[i].want));
    end

    // Oscillator loss at phase 2 of reset hold, then full restabilisation.
    step(1'b0, 1'b1, 1'b1);
    repeat (18) step(1'b1, 1'b1, 1'b1);
    chk("hold_phase2", 24'(phase4), 24'(4'b0100));
    step(1'b1, 1'b0, 1'b1);
    chk("osc_drop", 24'({phase4, stab4, sync4}), 24'({4'b0000, 1'b0, 1'b1}));
    repeat (15) step(1'b1, 1'b1, 1'b1);
    chk("restab_15", 24'(stab4), 24'(1'b0));
    step(1'b1, 1'b1, 1'b1);
    chk("restab_16", 24'({phase4, stab4}), 24'({4'b0001, 1'b1}));

    // Reach STOPPED, then reset pulse.
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("hold_release", 24'({phase4, sync4}), 24'({4'b0001, 1'b0}));
    repeat (4) step(1'b1, 1'b1, 1'b0);
    chk("stopped_ack", 24'({phase4, ack4}), 24'({4'b0000, 1'b1}));
    step(1'b0, 1'b1, 1'b0);
    chk("reset_in_stop", v4, 24'h000002);

    // CLK_ENA dropped mid-cycle but raised again before the INC cycle.
    repeat (24) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("toggle_inc", 24'({inc4, ack4}), 24'(2'b10));
    step(1'b1, 1'b1, 1'b1);
    chk("toggle_nostop", 24'({phase4, latch4, ack4}), 24'({4'b0001, 1'b1, 1'b0}));

    // 8-phase, DIV=3 instance: strobe widths over one machine cycle.
    step(1'b0, 1'b1, 1'b1);
    repeat (27) step(1'b1, 1'b1, 1'b1);
    main_cnt = 0; adr_low_cnt = 0; inc_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (i == 0) chk("p8_run_latch", 24'({phase8, latch8, sync8}), 24'({8'h01, 1'b1, 1'b0}));
      main_cnt    += int'(main8);
      adr_low_cnt += int'(!adr8);
      inc_cnt     += int'(inc8);
    end
    chk("p8_main_width", 24'(main_cnt), 24'd12);
    chk("p8_adr_low", 24'(adr_low_cnt), 24'd3);
    chk("p8_inc_width", 24'(inc_cnt), 24'd1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) != 0, $urandom_range(149) != 0, $urandom_range(3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
